// File: rtl/mux_scan_ctrl.sv
// Sweeps an external mux select from 0 to NUM_INPUTS-1, samples its output bit
// after a settle delay at each index, and publishes the reassembled word with a done pulse.
module mux_scan_ctrl #(
    parameter int NUM_INPUTS    = 8,
    parameter int SETTLE_CYCLES = 1,
    localparam int SW           = $clog2(NUM_INPUTS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_mux_out,
    output logic [SW-1:0]         o_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [NUM_INPUTS-1:0] o_word
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [SW-1:0]         r_idx;
    logic [NUM_INPUTS-1:0] r_scratch;
    logic [NUM_INPUTS-1:0] r_word;
    logic [NUM_INPUTS-1:0] w_merged;
    logic                  w_settleDone;
    logic                  w_lastIdx;

    assign w_settleDone = (r_cnt == CW'(SETTLE_CYCLES - 1));
    assign w_lastIdx    = (r_idx == SW'(NUM_INPUTS - 1));

    // Scratch word with the bit currently being sampled already merged in
    always_comb begin
        w_merged        = r_scratch;
        w_merged[r_idx] = i_mux_out;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                o_busy = 1'b1;
                if (w_settleDone) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                o_busy = 1'b1;
                w_next = w_lastIdx ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The index is cleared leaving DONE so IDLE always presents sel=0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_scratch <= '0;
            r_word    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (i_start) begin
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + CW'(1);
                end
                S_SAMPLE: begin
                    r_scratch <= w_merged;
                    r_cnt     <= '0;
                    if (w_lastIdx) begin
                        r_word <= w_merged;
                    end else begin
                        r_idx <= r_idx + SW'(1);
                    end
                end
                S_DONE: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign o_sel  = r_idx;
    assign o_word = r_word;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: three instances (defaults, SETTLE_CYCLES=3,
// NUM_INPUTS=5) each wrapped around a behavioural mux driven from bench vectors.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1, start2;
    logic [7:0]  a0, a1;
    logic [4:0]  a2;
    logic [2:0]  sel0, sel1, sel2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [7:0]  word0, word1;
    logic [4:0]  word2;
    logic        mux0, mux1, mux2;

    int checks   = 0;
    int failures = 0;
    int runNo    = 0;

    always #5 clk = ~clk;

    // Behavioural muxes in front of each scanner
    assign mux0 = a0[sel0];
    assign mux1 = a1[sel1];
    assign mux2 = (sel2 < 3'd5) ? a2[sel2] : 1'b0;

    mux_scan_ctrl dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_mux_out(mux0),
        .o_sel(sel0), .o_busy(busy0), .o_done(done0), .o_word(word0)
    );

    mux_scan_ctrl #(.NUM_INPUTS(8), .SETTLE_CYCLES(3)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_mux_out(mux1),
        .o_sel(sel1), .o_busy(busy1), .o_done(done1), .o_word(word1)
    );

    mux_scan_ctrl #(.NUM_INPUTS(5), .SETTLE_CYCLES(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_mux_out(mux2),
        .o_sel(sel2), .o_busy(busy2), .o_done(done2), .o_word(word2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input int d, input logic st, input logic [31:0] a);
        case (d)
            0: begin start0 = st; a0 = a[7:0]; end
            1: begin start1 = st; a1 = a[7:0]; end
            default: begin start2 = st; a2 = a[4:0]; end
        endcase
    endtask

    task automatic getOut(input int d, output logic [31:0] sel, output logic [31:0] busy,
                          output logic [31:0] done, output logic [31:0] word);
        case (d)
            0: begin sel = 32'(sel0); busy = 32'(busy0); done = 32'(done0); word = 32'(word0); end
            1: begin sel = 32'(sel1); busy = 32'(busy1); done = 32'(done1); word = 32'(word1); end
            default: begin sel = 32'(sel2); busy = 32'(busy2); done = 32'(done2); word = 32'(word2); end
        endcase
    endtask

    task automatic checkIdle(input int d, input logic [31:0] expWord, input string tag);
        logic [31:0] s, b, dn, w;
        getOut(d, s, b, dn, w);
        checkOutput({tag, " sel"}, s, 32'd0);
        checkOutput({tag, " busy"}, b, 32'd0);
        checkOutput({tag, " done"}, dn, 32'd0);
        checkOutput({tag, " word"}, w, expWord);
    endtask

    // Start is raised in the current cycle (cycle 0); every following cycle is
    // checked against the timing formulas for sel/busy/done/word.
    task automatic applyStimulus(input int d, input int s, input int n,
                                 input logic [31:0] aFirst, input logic [31:0] aSecond,
                                 input logic [31:0] wordBefore, input int cycles,
                                 input int holdStart, input int rstCyc,
                                 input int pulseA, input int pulseB);
        int          ns1;
        int          per;
        int          p;
        int          k;
        logic [31:0] expWord;
        logic [31:0] expSel, expBusy, expDone;
        logic [31:0] s_o, b_o, d_o, w_o;
        logic        st;
        string       tag;
        ns1     = n * (s + 1);
        per     = ns1 + 2;
        expWord = wordBefore;
        runNo++;
        setIn(d, 1'b1, aFirst);
        for (int c = 1; c <= cycles; c++) begin
            @(posedge clk);
            #1;
            p = holdStart ? (c % per) : c;
            k = holdStart ? (c / per) : 0;
            expSel  = 0;
            expBusy = 0;
            expDone = 0;
            if (rstCyc >= 0 && c > rstCyc) begin
                expWord = 0;
            end else if (p >= 1 && p <= ns1) begin
                expBusy = 1;
                expSel  = 32'((p - 1) / (s + 1));
            end else if (p == ns1 + 1) begin
                expDone = 1;
                expSel  = 32'(n - 1);
                expWord = (k == 0) ? aFirst : aSecond;
            end
            getOut(d, s_o, b_o, d_o, w_o);
            tag = $sformatf("r%0d c%0d", runNo, c);
            checkOutput({tag, " sel"}, s_o, expSel);
            checkOutput({tag, " busy"}, b_o, expBusy);
            checkOutput({tag, " done"}, d_o, expDone);
            checkOutput({tag, " word"}, w_o, expWord);
            st  = holdStart ? (c < cycles) : (c == pulseA || c == pulseB);
            rst = (c == rstCyc);
            setIn(d, st, (holdStart && c >= ns1 + 1) ? aSecond : aFirst);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        a0     = 8'h00;
        a1     = 8'h00;
        a2     = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        checkIdle(0, 32'h0, "rst0");
        checkIdle(1, 32'h0, "rst1");
        checkIdle(2, 32'h0, "rst2");
        rst    = 1'b0;
        start0 = 1'b0;
        @(posedge clk);
        #1;
        checkIdle(0, 32'h0, "postrst");

        $display("[TB] default scan a=AA");
        applyStimulus(0, 1, 8, 32'hAA, 32'hAA, 32'h00, 19, 0, -1, -1, -1);
        $display("[TB] start held, F0 then 0F");
        applyStimulus(0, 1, 8, 32'hF0, 32'h0F, 32'hAA, 36, 1, -1, -1, -1);
        $display("[TB] start pulses ignored mid-scan");
        applyStimulus(0, 1, 8, 32'hFF, 32'hFF, 32'h0F, 20, 0, -1, 3, 16);
        $display("[TB] reset mid-scan");
        applyStimulus(0, 1, 8, 32'hFF, 32'hFF, 32'hFF, 14, 0, 9, -1, -1);
        $display("[TB] fresh scan after reset");
        applyStimulus(0, 1, 8, 32'hFF, 32'hFF, 32'h00, 19, 0, -1, -1, -1);
        $display("[TB] SETTLE_CYCLES=3 a=CC");
        applyStimulus(1, 3, 8, 32'hCC, 32'hCC, 32'h00, 35, 0, -1, -1, -1);
        $display("[TB] NUM_INPUTS=5 a=10110");
        applyStimulus(2, 1, 5, 32'h16, 32'h16, 32'h00, 13, 0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer placed around the parameterised `mux` that reads all of its inputs one bit at a time. It drives the mux `sel` port and samples the mux `out` bit. On each `start` it sweeps `sel` from 0 to NUM_INPUTS-1, waits a programmable settle time at each index, and captures the selected bit. When the sweep finishes, it publishes the reassembled parallel word with a one-cycle `done` pulse.

## Interface

- NUM_INPUTS, 8, number of mux inputs; legal values ≥ 2, power of two not required.
- SETTLE_CYCLES, 1, cycles `sel` is held before sampling; legal values ≥ 1.
- SW = $clog2(NUM_INPUTS).

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  scan request; only sampled in IDLE.
- mux_out  in  1  connects to mux `out`.
- sel  out  SW  connects to mux `sel`.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse; `word` is valid from this cycle on.
- word  out  NUM_INPUTS  last completed scan, where word[i] = mux_out sampled with sel = i.

## Operation

- Internal state:
  - FSM: IDLE, SETTLE, SAMPLE, DONE.
  - Settle counter, width $clog2(SETTLE_CYCLES+1).
  - Index register: drives `sel`.
  - Scratch register: NUM_INPUTS bits.
- IDLE:
  - sel=0, busy=0.
  - If start=1: clear scratch and counter, sel=0, go to SETTLE.
- SETTLE:
  - busy=1, sel held constant.
  - Counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle):
  - busy=1.
  - Capture scratch[sel] <= mux_out at the end of this cycle.
  - If sel == NUM_INPUTS-1: word <= scratch with the final bit merged, go to DONE.
  - Else: sel <= sel+1, counter cleared, go to SETTLE.
- DONE (one cycle):
  - done=1, busy=0, sel=NUM_INPUTS-1 held.
  - Next state is IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE. It is neither queued nor counted.
- `word` changes only at the edge entering DONE. Partial results never appear on `word`.
- `sel` never exceeds NUM_INPUTS-1, including for non-power-of-two NUM_INPUTS.
- Changes on the mux data inputs during a scan are reflected only for indices not yet sampled.

## Timing

- Reset values: sel=0, busy=0, done=0, word=0, scratch=0, counter=0, state=IDLE.
- Reset mid-scan aborts the scan. No `done` pulse is produced and `word` is cleared.
- Cycle numbering, with start=1 in IDLE during cycle 0:
  - SETTLE for index i occupies cycles i·(S+1)+1 … i·(S+1)+S, where S = SETTLE_CYCLES.
  - SAMPLE for index i occupies cycle (i+1)·(S+1).
  - done=1 in cycle N·(S+1)+1, where N = NUM_INPUTS.
- Latency from the start cycle to the done cycle is N·(S+1)+1; for defaults, 17 cycles.
- busy rises in cycle 1 and falls in the done cycle.
- Earliest next accepted start: cycle N·(S+1)+2 (IDLE).
- If start is held high continuously, scans run back-to-back with period N·(S+1)+2 cycles.
- The sample point is S cycles after `sel` changes, so the mux combinational path has S full cycles to settle.
- rst and start asserted in the same cycle: rst wins and the FSM stays in IDLE.

## Test plan

- Defaults, mux a=8'b10101010, one start pulse:
  - sel steps 0..7, each value held 2 cycles.
  - busy high for 16 cycles.
  - done pulses 17 cycles after start; word=8'hAA.
- SETTLE_CYCLES=3, a=8'b11001100:
  - each sel value held 4 cycles.
  - done at cycle 33; word=8'hCC.
- start held high, a=8'b11110000 then 8'b00001111 applied before the second scan:
  - two done pulses 18 cycles apart.
  - word=8'hF0, then word=8'h0F.
- start pulsed again in cycles 3 and 16 of a scan with a=8'hFF:
  - exactly one done pulse; word=8'hFF.
- rst asserted in cycle 9 of a scan (a=8'hFF):
  - next cycle shows sel=0, busy=0, word=0.
  - no done pulse.
  - a fresh start then yields word=8'hFF at cycle 17.
- NUM_INPUTS=5, a=5'b10110:
  - sel covers 0..4 only.
  - done at cycle 11; word=5'b10110.
